lpc_synth: RTL and testbench
============================

Name: lpc_synth

Overview:
- Downstream LPC decode stage. Consumes one frame of encoder output: predictor coefficients A1..A10, voiced flag, pitch period and gain.
- Generates excitation per sample: an impulse train when voiced, LFSR ±gain noise when unvoiced.
- Passes the excitation through a 10th-order all-pole direct-form synthesis filter, using one shared multiplier sequenced over the taps.
- Runs entirely on d_clk. One output sample per sample_req.

Parameters:
- ORDER, 10, number of predictor taps; fixes MAC length at ORDER cycles.
- COEF_FRAC, 12, fractional bits of coefficients (Q3.12, 4096 = 1.0).
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.

Ports:
- d_clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- coef  input  160  {A10,...,A1}, each signed 16-bit Q3.12, A1 in bits [15:0]; A0 is not used.
- voiced_in  input  1  frame voiced flag.
- pitch_in  input  16  pitch period in samples, unsigned.
- gain_in  input  16  excitation amplitude, signed; only non-negative values are meaningful.
- frame_load  input  1  one-cycle strobe: capture coef/voiced_in/pitch_in/gain_in.
- sample_req  input  1  one-cycle strobe: produce the next output sample.
- busy  output  1  high while a sample is being computed.
- y  output  16  signed synthesized sample, held until the next y_valid.
- y_valid  output  1  one-cycle pulse when y updates.
- overrun  output  1  sticky; set when sample_req arrives while busy.

Behaviour:
- Reset: state IDLE; y=0, y_valid=0, busy=0, overrun=0. History y[n-1..n-10]=0, pitch_cnt=0, lfsr=LFSR_SEED. Shadow coef/voiced/pitch/gain=0, so output is 0 until the first frame. An active frame_load or sample_req on the same cycle as rst is discarded.
- Reset mid-operation: aborts the sample, no y_valid, history cleared. busy=0 on the following cycle.
- frame_load:
  - In IDLE: shadow registers are written on the next edge.
  - In any other state: inputs are captured into a pending buffer with a pending flag, and applied on the edge that returns to IDLE.
  - The sample in flight always uses the old frame.
  - A second frame_load while pending overwrites the buffer.
  - pitch_cnt is not cleared by frame_load.
- sample_req in IDLE, sampled at edge t:
  - EXC at t+1.
  - MAC for k=1..ORDER on cycles t+2..t+11.
  - OUT at t+12.
  - y and y_valid=1 on cycle t+13, when state is IDLE.
  - busy=1 on cycles t+1..t+12.
  - Minimum request spacing is 13 cycles.
  - sample_req outside IDLE is ignored and sets overrun.
  - A request arriving on cycle t+13 is accepted.
- EXC state:
  - Voiced: e = gain if pitch_cnt==0, else e = 0.
  - Unvoiced: e = +gain if lfsr[0]==1, else e = -gain.
  - lfsr advances once per sample in both modes: Fibonacci x^16+x^14+x^13+x^11, new bit = l[15]^l[13]^l[12]^l[10], shifted in at bit 0.
  - pitch_cnt <= (pitch_cnt+1 >= pitch) ? 0 : pitch_cnt+1, so pitch of 0 or 1 gives an impulse every sample.
  - acc (40-bit signed) <= sign-extended e << COEF_FRAC.
- MAC state, cycle k: acc <= acc - A_k * y[n-k]. The product is full 32-bit signed, sign-extended to 40 bits. No intermediate saturation.
- OUT state:
  - s = acc >>> COEF_FRAC (arithmetic shift, truncation toward -inf).
  - y = s clamped to [-32768, 32767].
  - History shifts: y[n-k] <= y[n-k+1], y[n-1] <= clamped y. The history stores the saturated value.

Test Plan:
- Frame voiced=1, pitch=4, gain=1000, coef=0; 9 requests at 13-cycle spacing -> y = 1000,0,0,0,1000,0,0,0,1000; each y_valid exactly 13 cycles after its sample_req.
- A1=-2048 (-0.5), others 0, voiced, pitch=100, gain=1000 -> y = 1000,500,250,125,62,31,15,7.
- A1=-8192 (-2.0), others 0, voiced, pitch=100, gain=1000 -> y = 1000,2000,4000,8000,16000,32000,32767,32767 (saturation; history holds 32767).
- Unvoiced, gain=500, coef=0, 32 samples -> each y = ±500, sign matching a software LFSR model seeded 0xACE1 (first sample +500, since lfsr[0]=1).
- sample_req 5 cycles after an accepted request -> ignored, overrun=1, only one y_valid. frame_load during MAC with new A1 -> current sample uses old A1, next sample uses new A1.
- rst pulsed during MAC -> no y_valid, y=0, busy=0 next cycle; following sample with coef=0, voiced, pitch=4, gain=1000 -> y = 1000 (pitch_cnt and history cleared).

Source files
------------

// File: rtl/lpc_synth.sv
// LPC synthesis stage: impulse/noise excitation into a 10th-order all-pole filter,
// one output sample per request, one shared multiplier stepped over the taps.
module lpc_synth #(
    parameter int unsigned ORDER     = 10,
    parameter int unsigned COEF_FRAC = 12,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    d_clk,
    input  logic                    rst,
    input  logic [16*ORDER-1:0]     coef,
    input  logic                    voiced_in,
    input  logic [15:0]             pitch_in,
    input  logic signed [15:0]      gain_in,
    input  logic                    frame_load,
    input  logic                    sample_req,
    output logic                    busy,
    output logic signed [15:0]      y,
    output logic                    y_valid,
    output logic                    overrun
);

    localparam int unsigned TapW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [TapW-1:0] LastTap = TapW'(ORDER - 1);
    localparam int unsigned AccW = 40;

    typedef enum logic [1:0] {StIdle, StExc, StMac, StOut} state_e;

    state_e state_q, state_d;

    // Shadow frame used by the sample in flight
    logic signed [15:0]  coef_q [ORDER];
    logic signed [15:0]  coef_d [ORDER];
    logic                voiced_q, voiced_d;
    logic [15:0]         pitch_q, pitch_d;
    logic signed [15:0]  gain_q, gain_d;

    logic [16*ORDER-1:0] pend_coef_q, pend_coef_d;
    logic                pend_voiced_q, pend_voiced_d;
    logic [15:0]         pend_pitch_q, pend_pitch_d;
    logic signed [15:0]  pend_gain_q, pend_gain_d;
    logic                pend_valid_q, pend_valid_d;

    logic signed [15:0]  hist_q [ORDER];
    logic signed [15:0]  hist_d [ORDER];
    logic [15:0]         pitch_cnt_q, pitch_cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [TapW-1:0]     tap_idx_q, tap_idx_d;
    logic signed [15:0]  y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic                overrun_q, overrun_d;

    logic signed [16:0]     exc;
    logic signed [31:0]     prod;
    logic [16:0]            pitch_inc;
    logic                   lfsr_fb;
    logic signed [AccW-1:0] acc_shift;
    logic signed [15:0]     y_sat;

    // -gain needs 17 bits when gain is -32768
    assign exc = voiced_q ? ((pitch_cnt_q == '0) ? 17'(gain_q) : 17'sd0)
                          : (lfsr_q[0] ? 17'(gain_q) : -17'(gain_q));
    assign prod      = coef_q[tap_idx_q] * hist_q[tap_idx_q];
    assign pitch_inc = {1'b0, pitch_cnt_q} + 17'd1;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign acc_shift = acc_q >>> COEF_FRAC;

    always_comb begin
        y_sat = acc_shift[15:0];
        if (acc_shift > 40'sd32767) begin
            y_sat = 16'sd32767;
        end else if (acc_shift < -40'sd32768) begin
            y_sat = -16'sd32768;
        end
    end

    // State register
    always_ff @(posedge d_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (sample_req) state_d = StExc;
            StExc:  state_d = StMac;
            StMac:  if (tap_idx_q == LastTap) state_d = StOut;
            StOut:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Datapath next-state
    always_comb begin
        coef_d        = coef_q;
        voiced_d      = voiced_q;
        pitch_d       = pitch_q;
        gain_d        = gain_q;
        pend_coef_d   = pend_coef_q;
        pend_voiced_d = pend_voiced_q;
        pend_pitch_d  = pend_pitch_q;
        pend_gain_d   = pend_gain_q;
        pend_valid_d  = pend_valid_q;
        hist_d        = hist_q;
        pitch_cnt_d   = pitch_cnt_q;
        lfsr_d        = lfsr_q;
        acc_d         = acc_q;
        tap_idx_d     = tap_idx_q;
        y_d           = y_q;
        y_valid_d     = 1'b0;
        overrun_d     = overrun_q | (sample_req & (state_q != StIdle));

        // A load in OUT lands on the edge back to IDLE, so it can go straight to the shadow
        if (frame_load) begin
            if (state_q == StIdle || state_q == StOut) begin
                for (int k = 0; k < ORDER; k++) coef_d[k] = coef[16*k +: 16];
                voiced_d     = voiced_in;
                pitch_d      = pitch_in;
                gain_d       = gain_in;
                pend_valid_d = 1'b0;
            end else begin
                pend_coef_d   = coef;
                pend_voiced_d = voiced_in;
                pend_pitch_d  = pitch_in;
                pend_gain_d   = gain_in;
                pend_valid_d  = 1'b1;
            end
        end else if (state_q == StOut && pend_valid_q) begin
            for (int k = 0; k < ORDER; k++) coef_d[k] = pend_coef_q[16*k +: 16];
            voiced_d     = pend_voiced_q;
            pitch_d      = pend_pitch_q;
            gain_d       = pend_gain_q;
            pend_valid_d = 1'b0;
        end

        unique case (state_q)
            StExc: begin
                acc_d       = $signed({{(AccW-17-COEF_FRAC){exc[16]}}, exc,
                                       {COEF_FRAC{1'b0}}});
                lfsr_d      = {lfsr_q[14:0], lfsr_fb};
                pitch_cnt_d = (pitch_inc >= {1'b0, pitch_q}) ? 16'd0 : pitch_inc[15:0];
                tap_idx_d   = '0;
            end
            StMac: begin
                acc_d     = acc_q - $signed({{(AccW-32){prod[31]}}, prod});
                tap_idx_d = tap_idx_q + TapW'(1);
            end
            StOut: begin
                y_d       = y_sat;
                y_valid_d = 1'b1;
                for (int k = ORDER - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
                hist_d[0] = y_sat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge d_clk) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                coef_q[k] <= '0;
                hist_q[k] <= '0;
            end
            voiced_q      <= 1'b0;
            pitch_q       <= '0;
            gain_q        <= '0;
            pend_coef_q   <= '0;
            pend_voiced_q <= 1'b0;
            pend_pitch_q  <= '0;
            pend_gain_q   <= '0;
            pend_valid_q  <= 1'b0;
            pitch_cnt_q   <= '0;
            lfsr_q        <= LFSR_SEED;
            acc_q         <= '0;
            tap_idx_q     <= '0;
            y_q           <= '0;
            y_valid_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            coef_q        <= coef_d;
            hist_q        <= hist_d;
            voiced_q      <= voiced_d;
            pitch_q       <= pitch_d;
            gain_q        <= gain_d;
            pend_coef_q   <= pend_coef_d;
            pend_voiced_q <= pend_voiced_d;
            pend_pitch_q  <= pend_pitch_d;
            pend_gain_q   <= pend_gain_d;
            pend_valid_q  <= pend_valid_d;
            pitch_cnt_q   <= pitch_cnt_d;
            lfsr_q        <= lfsr_d;
            acc_q         <= acc_d;
            tap_idx_q     <= tap_idx_d;
            y_q           <= y_d;
            y_valid_q     <= y_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_lpc_synth.sv
// Bench for lpc_synth: directed scenarios plus random frames against an arithmetic model.
module tb_lpc_synth;

    logic                d_clk = 1'b0;
    logic                rst;
    logic [159:0]        coef;
    logic                voiced_in;
    logic [15:0]         pitch_in;
    logic signed [15:0]  gain_in;
    logic                frame_load;
    logic                sample_req;
    logic                busy;
    logic signed [15:0]  y;
    logic                y_valid;
    logic                overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 d_clk = ~d_clk;

    lpc_synth dut (
        .d_clk      (d_clk),
        .rst        (rst),
        .coef       (coef),
        .voiced_in  (voiced_in),
        .pitch_in   (pitch_in),
        .gain_in    (gain_in),
        .frame_load (frame_load),
        .sample_req (sample_req),
        .busy       (busy),
        .y          (y),
        .y_valid    (y_valid),
        .overrun    (overrun)
    );

    // Reference model state
    logic [159:0] m_coef;
    bit           m_voiced;
    int           m_pitch;
    int           m_gain;
    longint       m_hist [10];
    int           m_pcnt;
    logic [15:0]  m_lfsr;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_coef   = '0;
        m_voiced = 1'b0;
        m_pitch  = 0;
        m_gain   = 0;
        m_pcnt   = 0;
        m_lfsr   = 16'hACE1;
        for (int k = 0; k < 10; k++) m_hist[k] = 0;
    endfunction

    function automatic longint model_step();
        longint e, acc, s;
        logic signed [15:0] a;
        if (m_voiced) e = (m_pcnt == 0) ? m_gain : 0;
        else          e = m_lfsr[0] ? m_gain : -m_gain;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_pcnt = (m_pcnt + 1 >= m_pitch) ? 0 : m_pcnt + 1;
        acc = e * 4096;
        for (int k = 0; k < 10; k++) begin
            a = m_coef[16*k +: 16];
            acc = acc - longint'(a) * m_hist[k];
        end
        s = acc >>> 12;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        for (int k = 9; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
        return s;
    endfunction

    task automatic set_inputs(input logic [159:0] c, input logic v, input logic [15:0] p,
                              input logic signed [15:0] g);
        coef      = c;
        voiced_in = v;
        pitch_in  = p;
        gain_in   = g;
    endtask

    task automatic adopt_inputs();
        m_coef   = coef;
        m_voiced = voiced_in;
        m_pitch  = int'(pitch_in);
        m_gain   = int'(gain_in);
    endtask

    task automatic load_frame(input logic [159:0] c, input logic v, input logic [15:0] p,
                              input logic signed [15:0] g);
        set_inputs(c, v, p, g);
        frame_load = 1'b1;
        @(negedge d_clk);
        frame_load = 1'b0;
        adopt_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge d_clk);
        rst = 1'b0;
        model_reset();
    endtask

    // extra: 0 plain, 1 frame_load mid-MAC, 2 second request mid-MAC, 3 reset mid-MAC
    task automatic req_sample(input int extra, output longint got);
        longint exp_y;
        int n, cnt;
        exp_y = 0;
        if (extra != 3) exp_y = model_step();
        sample_req = 1'b1;
        @(negedge d_clk);
        sample_req = 1'b0;
        n = 1;
        chk("busy_after_req", busy, 1);
        if (extra == 3) begin
            while (n < 5) begin
                @(negedge d_clk);
                n++;
            end
            rst = 1'b1;
            @(negedge d_clk);
            rst = 1'b0;
            chk("busy_after_rst", busy, 0);
            cnt = y_valid ? 1 : 0;
            repeat (16) begin
                @(negedge d_clk);
                if (y_valid) cnt++;
            end
            chk("valid_after_rst", cnt, 0);
            chk("y_after_rst", y, 0);
            model_reset();
            got = y;
        end else begin
            while (!y_valid && n < 20) begin
                if (n == 5 && extra == 1) frame_load = 1'b1;
                if (n == 5 && extra == 2) sample_req = 1'b1;
                @(negedge d_clk);
                n++;
                frame_load = 1'b0;
                sample_req = 1'b0;
            end
            chk("latency", n, 13);
            chk("y", y, exp_y);
            got = y;
            if (extra == 1) adopt_inputs();
            if (extra == 2) begin
                chk("overrun", overrun, 1);
                cnt = 0;
                repeat (14) begin
                    @(negedge d_clk);
                    if (y_valid) cnt++;
                end
                chk("stray_valid", cnt, 0);
            end
        end
    endtask

    initial begin
        longint got;
        logic [159:0] c;
        int exp_a [9];
        int exp_b [8];
        int exp_c [8];
        exp_a = '{1000, 0, 0, 0, 1000, 0, 0, 0, 1000};
        exp_b = '{1000, 500, 250, 125, 62, 31, 15, 7};
        exp_c = '{1000, 2000, 4000, 8000, 16000, 32000, 32767, 32767};

        rst        = 1'b1;
        frame_load = 1'b0;
        sample_req = 1'b0;
        set_inputs('0, 1'b0, 16'd0, 16'sd0);
        repeat (3) @(negedge d_clk);
        rst = 1'b0;
        model_reset();
        chk("rst_y", y, 0);
        chk("rst_valid", y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // No frame loaded yet: output stays zero
        req_sample(0, got);
        chk("no_frame_y", got, 0);

        do_reset();
        load_frame('0, 1'b1, 16'd4, 16'sd1000);
        for (int i = 0; i < 9; i++) begin
            req_sample(0, got);
            chk("impulse_train", got, exp_a[i]);
        end

        do_reset();
        c = '0;
        c[15:0] = 16'hF800;
        load_frame(c, 1'b1, 16'd100, 16'sd1000);
        for (int i = 0; i < 8; i++) begin
            req_sample(0, got);
            chk("decay", got, exp_b[i]);
        end

        do_reset();
        c = '0;
        c[15:0] = 16'hE000;
        load_frame(c, 1'b1, 16'd100, 16'sd1000);
        for (int i = 0; i < 8; i++) begin
            req_sample(0, got);
            chk("saturate", got, exp_c[i]);
        end

        do_reset();
        load_frame('0, 1'b0, 16'd0, 16'sd500);
        for (int i = 0; i < 32; i++) begin
            req_sample(0, got);
            if (i == 0) chk("noise_first", got, 500);
            chk("noise_mag", (got < 0) ? -got : got, 500);
        end

        // Overrun, then frame_load while busy
        do_reset();
        c = '0;
        c[15:0] = 16'hF800;
        load_frame(c, 1'b1, 16'd100, 16'sd1000);
        req_sample(2, got);
        chk("overrun_y", got, 1000);
        c[15:0] = 16'hE000;
        set_inputs(c, 1'b1, 16'd100, 16'sd1000);
        req_sample(1, got);
        chk("old_coef_in_flight", got, 500);
        req_sample(0, got);
        chk("new_coef_next", got, 1000);

        // Reset in the middle of MAC
        do_reset();
        load_frame('0, 1'b1, 16'd4, 16'sd1000);
        req_sample(0, got);
        req_sample(3, got);
        load_frame('0, 1'b1, 16'd4, 16'sd1000);
        req_sample(0, got);
        chk("after_rst_sample", got, 1000);

        // Random frames, some loaded while a sample is in flight
        do_reset();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 10; k++) c[16*k +: 16] = 16'($urandom_range(0, 2047)) - 16'd1024;
            load_frame(c, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 8)),
                       16'($urandom_range(0, 3000)));
            for (int s = 0; s < 6; s++) begin
                if ($urandom_range(0, 4) == 0) begin
                    for (int k = 0; k < 10; k++)
                        c[16*k +: 16] = 16'($urandom_range(0, 2047)) - 16'd1024;
                    set_inputs(c, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 8)),
                               16'($urandom_range(0, 3000)));
                    req_sample(1, got);
                end else begin
                    req_sample(0, got);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
